instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
// Fetch stage directly upstream of the control decoder. Holds the PC, fetches
// 32-bit words from instruction memory over a req/ack handshake, and buffers
// them in a 2-entry FIFO. Presents opcode [31:26] and funct [5:0] to the decoder
// with PC+4, the link value written to r31 by bneal/balrn/jmsub. Accepts PC
// redirects from branch/jump resolution (beq, bneal, balrn, jrs, jmsub).
// PARAMETERS
// RESET_PC    32'h0000_0000  PC loaded on reset; must be word aligned
// ADDR_W      32             PC / imem address width
// PORTS
// clk           in   1       rising-edge clock
// rst_n         in   1       asynchronous reset, active low
// imem_req      out  1       fetch request; held with imem_addr stable until imem_ack
// imem_addr     out  ADDR_W  word-aligned fetch address ([1:0] always 2'b00)
// imem_ack      in   1       read data valid this cycle; ends the request
// imem_rdata    in   32      instruction word, sampled when imem_ack=1
// redirect_valid in  1       taken branch/jump; flush and refetch
// redirect_pc   in   ADDR_W  new PC; bits [1:0] ignored and forced to 0
// dec_ready     in   1       decoder consumes dec_* this cycle
// dec_valid     out  1       FIFO head valid
// dec_instr     out  32      FIFO head instruction word
// dec_opcode    out  6       dec_instr[31:26], to control opcode input
// dec_funct     out  6       dec_instr[5:0], to control funct input
// dec_pc4       out  ADDR_W  fetch address of head + 4 (link address)
// BEHAVIOUR
// - Reset (async, rst_n=0): pc=RESET_PC, state=RST, imem_req=0,
//   imem_addr=RESET_PC, FIFO empty, dec_valid=0, dec_instr=0, dec_pc4=0.
// - States: RST -> FETCH on the first clock after rst_n rises. FETCH: imem_req=1
//   at addr=pc. On ack, push {rdata, pc+4}, pc<=pc+4. After that ack, stay in
//   FETCH if the FIFO keeps >=1 free slot after the push, else go to WAIT.
//   WAIT: imem_req=0; -> FETCH the cycle after a pop frees a slot.
//   KILL: request is outstanding but flushed; imem_req stays 1 at the old addr
//   until ack. Ack data is discarded, then -> FETCH at the new pc.
// - A request is never withdrawn or changed before ack, even on redirect.
// - Issue rule: imem_req asserts only when (FIFO count + outstanding) < 2, so a
//   push never overflows. A push and pop in the same cycle are both honoured.
// - Latency: ack in cycle N -> dec_valid=1 in N+1 (FIFO empty case). Throughput
//   is 1 instr/cycle with single-cycle ack and dec_ready held at 1.
// - Pop: dec_valid & dec_ready. dec_* are registered FIFO-head outputs; they hold
//   stable while dec_valid=1 and dec_ready=0.
// - Redirect in cycle N: FIFO cleared, so dec_valid=0 in N+1. pc<={redirect_pc
//   [ADDR_W-1:2],2'b00}. With no request outstanding, the new request issues in
//   N+1. With a request outstanding and no ack in N, go to KILL. An ack in the
//   same cycle as the redirect is discarded and the request issues in N+1.
//   A redirect while in KILL updates pc only; last redirect wins. A redirect
//   wins over a simultaneous pop; the pop is ignored.
// - pc arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
// - An ack is ignored in RST and WAIT. Reset mid-request abandons it; imem
//   must tolerate a dropped req.
// TESTING
// 1 reset, imem acks 1 cycle after req, dec_ready=1 -> addrs 0,4,8...;
//   dec_pc4 0x4,0x8,...; dec_valid rises 2 cycles after rst_n release
// 2 dec_ready=0, imem acks every cycle -> 2 words buffered, imem_req low (WAIT);
//   one pop -> exactly one new req, outputs stable while stalled
// 3 redirect_pc=0x0000_0103 with req at 0x10 pending, ack 3 cycles later
//   -> 0x10 data dropped, next req addr 0x100, dec_valid=0 until 0x100 arrives
// 4 redirect coincident with ack and a valid head -> ack data and head both
//   discarded, req to redirect target next cycle, no spurious dec_valid
// 5 pc=0xFFFF_FFFC fetched -> dec_pc4=0x0, next imem_addr=0x0
// 6 rst_n pulsed low mid-request, late ack after release -> ignored;
//   fetch restarts at RESET_PC

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack channel, redirect input
// from branch/jump resolution, and the decoder-facing FIFO head.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              dec_ready;
  logic              dec_valid;
  logic [31:0]       dec_instr;
  logic [5:0]        dec_opcode;
  logic [5:0]        dec_funct;
  logic [ADDR_W-1:0] dec_pc4;

  // The fetch unit drives imem requests and the decoder outputs.
  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_opcode, dec_funct, dec_pc4,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, dec_ready
  );

  // Memory / decoder / branch-resolution side.
  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_opcode, dec_funct, dec_pc4,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches words over a req/ack channel
// into a 2-entry FIFO and presents the head (instr, opcode, funct, PC+4) to the
// decoder. Redirects flush the FIFO; an in-flight request is never withdrawn,
// its returning data is dropped instead (KILL state).
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    ST_RST,
    ST_FETCH,
    ST_WAIT,
    ST_KILL
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc4;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] kill_addr_q, kill_addr_d;
  entry_t            head_q, head_d;
  entry_t            tail_q, tail_d;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] redirect_target;
  logic              pop;
  logic              push;
  logic [1:0]        count_cur;
  logic [1:0]        count_nxt;
  logic              req;
  logic [ADDR_W-1:0] addr;
  entry_t            new_entry;

  // Handshake qualifiers: a redirect overrides both pop and push this cycle.
  always_comb begin
    pc_plus4        = pc_q + ADDR_W'(4);
    redirect_target = bus.redirect_pc & ~ADDR_W'(3);
    pop             = head_q.valid & bus.dec_ready & ~bus.redirect_valid;
    push            = (state_q == ST_FETCH) & bus.imem_ack & ~bus.redirect_valid;
    count_cur       = 2'(head_q.valid) + 2'(tail_q.valid);
    count_nxt       = count_cur - 2'(pop) + 2'(push);
  end

  // Next-state, PC and request outputs of the fetch FSM.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    req         = 1'b0;
    addr        = pc_q;
    unique case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
        if (bus.redirect_valid) pc_d = redirect_target;
      end
      ST_FETCH: begin
        req = 1'b1;
        if (bus.redirect_valid) begin
          pc_d = redirect_target;
          // Request still in flight: remember its address and drop its data.
          if (!bus.imem_ack) begin
            state_d     = ST_KILL;
            kill_addr_d = pc_q;
          end
        end else if (bus.imem_ack) begin
          pc_d    = pc_plus4;
          state_d = (count_nxt == 2'd2) ? ST_WAIT : ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (bus.redirect_valid) begin
          pc_d    = redirect_target;
          state_d = ST_FETCH;
        end else if (count_nxt < 2'd2) begin
          state_d = ST_FETCH;
        end
      end
      ST_KILL: begin
        req  = 1'b1;
        addr = kill_addr_q;
        if (bus.redirect_valid) pc_d = redirect_target;
        if (bus.imem_ack) state_d = ST_FETCH;
      end
      default: state_d = ST_RST;
    endcase
  end

  // Two-entry shift FIFO: head is always the decoder-visible entry.
  always_comb begin
    new_entry = '{valid: 1'b1, instr: bus.imem_rdata, pc4: pc_plus4};
    head_d    = head_q;
    tail_d    = tail_q;
    if (bus.redirect_valid) begin
      head_d.valid = 1'b0;
      tail_d.valid = 1'b0;
    end else begin
      if (pop) begin
        head_d       = tail_q;
        tail_d.valid = 1'b0;
      end
      if (push) begin
        if (head_d.valid) tail_d = new_entry;
        else              head_d = new_entry;
      end
    end
  end

  // State, PC and FIFO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      pc_q        <= RESET_PC;
      kill_addr_q <= RESET_PC;
      // NOTE: the FIFO storage is reset (not just its valid bits) because the
      // head drives dec_instr/dec_pc4 directly and those must read 0 out of reset.
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational blocks.
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = addr;
  assign bus.dec_valid  = head_q.valid;
  assign bus.dec_instr  = head_q.instr;
  assign bus.dec_opcode = head_q.instr[31:26];
  assign bus.dec_funct  = head_q.instr[5:0];
  assign bus.dec_pc4    = head_q.pc4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a behavioural imem answers requests with
// a programmable delay; a scoreboard queue holds the expected FIFO contents and
// is compared against the decoder outputs every cycle.
module tb_instr_fetch_unit;
  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard entries: {instr, pc4}.
  logic [63:0] sb[$];
  logic [31:0] exp_pc    = RESET_PC;
  logic [31:0] kill_addr = RESET_PC;
  bit          kill      = 1'b0;
  bit          in_rst    = 1'b0;

  // Memory model controls.
  int ack_delay = 0;
  int wait_cnt  = 0;
  bit force_ack = 1'b0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered just after a falling edge with dec_ready and
  // redirect already applied: memory answers, outputs are compared with the
  // scoreboard, the scoreboard is advanced for the coming rising edge.
  task automatic cycle();
    logic        exp_req;
    logic        ack_eff;
    logic [63:0] hd;
    if (force_ack) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
    end else if (bus.imem_req && wait_cnt >= ack_delay) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = data_of(bus.imem_addr);
      wait_cnt       = 0;
    end else begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'h0BAD_F00D;
      if (bus.imem_req) wait_cnt++;
      else              wait_cnt = 0;
    end

    exp_req = !in_rst && (kill || sb.size() < 2);
    check("imem_req", 64'(bus.imem_req), 64'(exp_req));
    if (exp_req) check("imem_addr", 64'(bus.imem_addr), 64'(kill ? kill_addr : exp_pc));
    check("dec_valid", 64'(bus.dec_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      hd = sb[0];
      check("dec_instr",  64'(bus.dec_instr),  64'(hd[63:32]));
      check("dec_opcode", 64'(bus.dec_opcode), 64'(hd[63:58]));
      check("dec_funct",  64'(bus.dec_funct),  64'(hd[37:32]));
      check("dec_pc4",    64'(bus.dec_pc4),    64'(hd[31:0]));
    end

    ack_eff = exp_req && bus.imem_ack;
    if (bus.redirect_valid) begin
      sb.delete();
      if (exp_req && !ack_eff) begin
        if (!kill) kill_addr = exp_pc;
        kill = 1'b1;
      end else begin
        kill = 1'b0;
      end
      exp_pc = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (sb.size() != 0 && bus.dec_ready) void'(sb.pop_front());
      if (ack_eff) begin
        if (kill) begin
          kill = 1'b0;
        end else begin
          sb.push_back({data_of(exp_pc), exp_pc + 32'd4});
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    in_rst = 1'b0;

    @(negedge clk);
    bus.redirect_valid = 1'b0;
    force_ack          = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n              = 1'b0;
    bus.imem_ack       = 1'b0;
    bus.redirect_valid = 1'b0;
    sb.delete();
    kill     = 1'b0;
    exp_pc   = RESET_PC;
    wait_cnt = 0;
    #1;
    for (int i = 0; i < n; i++) begin
      check("rst_imem_req",  64'(bus.imem_req),  64'd0);
      check("rst_imem_addr", 64'(bus.imem_addr), 64'(RESET_PC));
      check("rst_dec_valid", 64'(bus.dec_valid), 64'd0);
      check("rst_dec_instr", 64'(bus.dec_instr), 64'd0);
      check("rst_dec_pc4",   64'(bus.dec_pc4),   64'd0);
      @(negedge clk);
    end
    rst_n  = 1'b1;
    in_rst = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
  endtask

  // Fill the FIFO with the decoder stalled so no request is left in flight.
  task automatic fill_and_park();
    ack_delay     = 0;
    bus.dec_ready = 1'b0;
    repeat (6) cycle();
    check("park_req_low", 64'(bus.imem_req), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    bus.imem_ack       = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 1'b0;
    @(negedge clk);
    do_reset(2);

    // Streaming from reset: single-cycle ack, decoder always ready.
    bus.dec_ready = 1'b1;
    ack_delay     = 0;
    repeat (10) cycle();
    ack_delay = 1;
    repeat (8) cycle();

    // Decoder stalled: two words buffered, request drops; one pop -> one request.
    fill_and_park();
    bus.dec_ready = 1'b1;
    cycle();
    bus.dec_ready = 1'b0;
    repeat (4) cycle();
    check("stall_req_low", 64'(bus.imem_req), 64'd0);

    // Redirect while a request to 0x10 is outstanding: its data is dropped.
    ack_delay     = 3;
    bus.dec_ready = 1'b1;
    redirect(32'h0000_0010);
    cycle();
    cycle();
    redirect(32'h0000_0103);
    cycle();
    check("kill_addr_held", 64'(bus.imem_addr), 64'h10);
    repeat (10) cycle();

    // Redirect coincident with an ack and a valid head.
    fill_and_park();
    redirect(32'h0000_0200);
    cycle();
    cycle();
    check("t4_head_valid", 64'(bus.dec_valid), 64'd1);
    redirect(32'h0000_0300);
    cycle();
    check("t4_no_valid", 64'(bus.dec_valid), 64'd0);
    check("t4_req_addr", 64'(bus.imem_addr), 64'h300);
    bus.dec_ready = 1'b1;
    repeat (5) cycle();

    // PC wrap at the top of the address space.
    fill_and_park();
    redirect(32'hFFFF_FFFD);
    cycle();
    check("wrap_addr_top", 64'(bus.imem_addr), 64'hFFFF_FFFC);
    cycle();
    check("wrap_pc4", 64'(bus.dec_pc4), 64'h0);
    check("wrap_next_addr", 64'(bus.imem_addr), 64'h0);
    bus.dec_ready = 1'b1;
    repeat (4) cycle();

    // Reset mid-request, with a late ack in the cycle after release.
    ack_delay     = 3;
    bus.dec_ready = 1'b1;
    redirect(32'h0000_0040);
    cycle();
    cycle();
    check("t6_req_pending", 64'(bus.imem_req), 64'd1);
    do_reset(2);
    ack_delay = 0;
    force_ack = 1'b1;
    cycle();
    check("t6_restart_addr", 64'(bus.imem_addr), 64'(RESET_PC));
    repeat (8) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
